// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a single-entry
// result register drained through a valid/ready handshake.

module arithmetic_unit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_term0,
    input  logic [WIDTH-1:0] i_term1,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_result
);

    // Modulo-2^WIDTH arithmetic: carry and borrow fall off the top.
    always_comb begin
        o_result = '0;
        case (i_sel)
            2'd0:    o_result = i_term0 + i_term1;
            2'd1:    o_result = i_term0 - i_term1;
            2'd2:    o_result = i_term0 & i_term1;
            2'd3:    o_result = i_term0 | i_term1;
            default: o_result = '0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_term0,
    input  logic [WIDTH-1:0] a_term1,
    input  logic [1:0]       a_sel,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_term0,
    input  logic [WIDTH-1:0] b_term1,
    input  logic [1:0]       b_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio_b;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_id;

    logic             w_accept_en;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_term0;
    logic [WIDTH-1:0] w_op_term1;
    logic [1:0]       w_op_sel;
    logic [WIDTH-1:0] w_alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The result slot can take a new op when empty, or when its current
    // occupant leaves this same cycle. Grants are masked while reset is high.
    always_comb begin
        w_state_nxt = r_state;
        w_accept_en = 1'b0;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;

        w_accept_en = (r_state == ST_IDLE) || ((r_state == ST_RESP) && res_ready);

        if (w_accept_en && !reset) begin
            if (a_valid && b_valid) begin
                w_gnt_a = !r_prio_b;
                w_gnt_b = r_prio_b;
            end else begin
                w_gnt_a = a_valid;
                w_gnt_b = b_valid;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_a || w_gnt_b) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready && !(w_gnt_a || w_gnt_b)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_gnt_a || w_gnt_b;
    assign a_ready  = w_gnt_a;
    assign b_ready  = w_gnt_b;

    assign w_op_term0 = w_gnt_b ? b_term0 : a_term0;
    assign w_op_term1 = w_gnt_b ? b_term1 : a_term1;
    assign w_op_sel   = w_gnt_b ? b_sel   : a_sel;

    arithmetic_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_term0  (w_op_term0),
        .i_term1  (w_op_term1),
        .i_sel    (w_op_sel),
        .o_result (w_alu_result)
    );

    // Pointer names who wins the next tie; it only moves on a real transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_b <= 1'b0;
        end else if (w_gnt_a) begin
            r_prio_b <= 1'b1;
        end else if (w_gnt_b) begin
            r_prio_b <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_data <= '0;
            r_res_id   <= 1'b0;
        end else if (w_accept) begin
            r_res_data <= w_alu_result;
            r_res_id   <= w_gnt_b;
        end
    end

    assign res_valid = (r_state == ST_RESP);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle model predicts grants and
// res_valid, and queued expected results are matched on each delivery.

module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [W-1:0] a_term0, a_term1, b_term0, b_term1;
    logic [1:0]   a_sel, b_sel;
    logic         res_valid, res_ready, res_id;
    logic [W-1:0] res_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [W:0]   sb_q[$];
    logic         m_busy = 1'b0;
    logic         m_prio_b = 1'b0;
    logic         a_fire = 1'b0;
    logic         b_fire = 1'b0;
    logic         m_hold = 1'b0;
    logic [W-1:0] m_last_data = '0;
    logic         m_last_id = 1'b0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_term0   (a_term0),
        .a_term1   (a_term1),
        .a_sel     (a_sel),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_term0   (b_term0),
        .b_term1   (b_term1),
        .b_sel     (b_sel),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [1:0] sel, input logic [W-1:0] t0,
                                             input logic [W-1:0] t1);
        case (sel)
            2'd0:    return t0 + t1;
            2'd1:    return t0 - t1;
            2'd2:    return t0 & t1;
            default: return t0 | t1;
        endcase
    endfunction

    // Monitor samples on the falling edge, midway between input updates.
    always @(negedge clk) begin
        logic       exp_en, exp_ga, exp_gb;
        logic [W:0] e;
        if (!reset) begin
            exp_en = !m_busy || res_ready;
            exp_ga = exp_en && a_valid && (!b_valid || !m_prio_b);
            exp_gb = exp_en && b_valid && !exp_ga;
            chk("a_ready", a_ready, exp_ga);
            chk("b_ready", b_ready, exp_gb);
            chk("res_valid", res_valid, m_busy);
            if (m_hold) begin
                chk("hold_data", res_data, m_last_data);
                chk("hold_id", res_id, m_last_id);
            end
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_data", res_data, e[W-1:0]);
                    chk("res_id", res_id, e[W]);
                end
            end
            m_hold      = res_valid && !res_ready;
            m_last_data = res_data;
            m_last_id   = res_id;
            if (exp_ga) begin
                sb_q.push_back({1'b0, alu_ref(a_sel, a_term0, a_term1)});
                m_prio_b = 1'b1;
            end
            if (exp_gb) begin
                sb_q.push_back({1'b1, alu_ref(b_sel, b_term0, b_term1)});
                m_prio_b = 1'b0;
            end
            m_busy = exp_ga || exp_gb || (m_busy && !res_ready);
            a_fire = a_valid && a_ready;
            b_fire = b_valid && b_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || res_valid); i++) step();
        chk("drain_left", sb_q.size(), 0);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        a_term0 = 32'd7; a_term1 = 32'd12; a_sel = 2'd2;
        b_term0 = 32'd6; b_term1 = 32'd9;  b_sel = 2'd3;

        // Asynchronous reset visible before any clock edge.
        #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Both requesters pending: A, B, A, B.
        repeat (4) step();
        drain();

        // A alone: 5 - 3 with one cycle latency.
        a_valid = 1'b1; a_term0 = 32'd5; a_term1 = 32'd3; a_sel = 2'd1;
        step();
        a_valid = 1'b0;
        chk("a_only_valid", res_valid, 1);
        chk("a_only_data", res_data, 2);
        chk("a_only_id", res_id, 0);
        drain();

        // Backpressure for three cycles, then B goes in on release.
        a_valid = 1'b1; a_term0 = 32'h1111; a_term1 = 32'h2222; a_sel = 2'd0;
        res_ready = 1'b0;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_term0 = 32'hA5; b_term1 = 32'h0F; b_sel = 2'd2;
        repeat (3) step();
        chk("bp_data", res_data, 32'h3333);
        chk("bp_id", res_id, 0);
        chk("bp_b_ready", b_ready, 0);
        res_ready = 1'b1;
        #1 chk("bp_release_b_ready", b_ready, 1);
        step();
        b_valid = 1'b0;
        chk("bp_new_valid", res_valid, 1);
        chk("bp_new_data", res_data, 32'h5);
        chk("bp_new_id", res_id, 1);
        drain();

        // Wraparound, back to back.
        a_valid = 1'b1; a_term0 = 32'hFFFF_FFFF; a_term1 = 32'd1; a_sel = 2'd0;
        step();
        chk("wrap_add", res_data, 32'h0);
        a_term0 = 32'd0; a_term1 = 32'd1; a_sel = 2'd1;
        step();
        chk("wrap_sub", res_data, 32'hFFFF_FFFF);
        drain();

        // Random traffic, requesters honour hold-while-stalled.
        a_valid = 1'b0; b_valid = 1'b0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (!a_valid || a_fire) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_term0 = rand_operand(); a_term1 = rand_operand();
                a_sel   = 2'($urandom_range(0, 3));
            end
            if (!b_valid || b_fire) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_term0 = rand_operand(); b_term1 = rand_operand();
                b_sel   = 2'($urandom_range(0, 3));
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset in the middle of a held result, pointer last moved by A.
        a_valid = 1'b1; a_term0 = 32'h1230; a_term1 = 32'h4; a_sel = 2'd0;
        res_ready = 1'b0;
        step();
        a_valid = 1'b0;
        step();
        chk("pre_rst_data", res_data, 32'h1234);
        chk("pre_rst_valid", res_valid, 1);
        #2;
        reset = 1'b1;
        sb_q.delete();
        m_busy = 1'b0; m_prio_b = 1'b0; m_hold = 1'b0;
        a_fire = 1'b0; b_fire = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        a_term0 = 32'd10; a_term1 = 32'd4; a_sel = 2'd1;
        b_term0 = 32'd3;  b_term1 = 32'd4; b_sel = 2'd0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_id", res_id, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        chk("post_rst_data", res_data, 32'd6);
        chk("post_rst_id", res_id, 0);
        step();
        b_valid = 1'b0;
        chk("post_rst_b_data", res_data, 32'd7);
        chk("post_rst_b_id", res_id, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
